logic_unit_pipe: RTL and testbench
==================================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of the accepted-transaction counter.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream offers op/a/b.
REQ-006 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-007 SHALL have port op, input, 3, operation select.
REQ-008 SHALL have ports a and b, input, WIDTH each, operands.
REQ-009 SHALL have port out_valid, output, 1, y/zero hold a valid result.
REQ-010 SHALL have port out_ready, input, 1, downstream takes the result.
REQ-011 SHALL have port y, output, WIDTH, result.
REQ-012 SHALL have port zero, output, 1, high when y == 0.
REQ-013 SHALL have port clr_count, input, 1, synchronous counter clear.
REQ-014 SHALL have port op_count, output, CNT_W, count of accepted inputs.

Function
REQ-015 SHALL compute, per op: 000 ~a; 001 a&b; 010 a|b; 011 a^b; 100 ~(a&b); 101 ~(a|b); 110 ~(a^b); 111 a (pass). All ops are bitwise over WIDTH, with no carries.
REQ-016 SHALL treat an input as accepted when in_valid && in_ready, and an output as transferred when out_valid && out_ready.
REQ-017 SHALL register the result: an input accepted in cycle N appears on y/zero with out_valid=1 in cycle N+1 when the pipe is empty (latency 1).
REQ-018 SHALL buffer up to 2 results (main register plus skid register) using state EMPTY/ONE/TWO.
REQ-019 EMPTY: accept -> ONE; otherwise stay.
REQ-020 ONE: accept without transfer -> TWO (new result into skid); accept with transfer -> ONE (new result into main); transfer without accept -> EMPTY; otherwise stay.
REQ-021 TWO: transfer -> ONE (skid moves to main); no accept possible.
REQ-022 SHALL drive in_ready = (state != TWO) from registered state only, with no combinational path from out_ready.
REQ-023 SHALL drive out_valid = (state != EMPTY) and hold y/zero stable while out_valid && !out_ready.
REQ-024 SHALL deliver results strictly in acceptance order, with no loss or duplication.
REQ-025 SHALL increment op_count by 1 per accepted input, wrapping from 2^CNT_W-1 to 0.
REQ-026 clr_count SHALL zero op_count next cycle; when clr_count and accept coincide, the clear wins (op_count=0).
REQ-027 SHALL ignore op/a/b when no accept occurs; an unaccepted in_valid SHALL change no state.

Reset
REQ-028 With rst_n low at a rising edge: state=EMPTY, out_valid=0, in_ready=1 (next cycle onward), y=0, zero=1, op_count=0.
REQ-029 Reset mid-operation SHALL discard all buffered results, and no transfer SHALL be reported in the reset cycle.
REQ-030 SHALL ignore in_valid during reset cycles.

Structure
REQ-031 Op encodings (OP_NOT..OP_PASS) and the state encoding SHALL live in shared package logic_unit_pkg.
REQ-032 Op evaluation SHALL be a combinational sub-module logic_op (params WIDTH; ports op, a, b, y), reused by future units.
REQ-033 The top level SHALL contain only the state register, the main/skid data registers and the counter.

Verification
REQ-034 WIDTH=8, out_ready=1, accept op=000 a=8'h0F -> next cycle y=8'hF0, zero=0, out_valid=1, op_count=1.
REQ-035 Sweep all 8 ops with a=8'hCC b=8'hAA -> y = 88,EE,66,77,11,99,CC in op order, starting 33 for op=000; op=110 a=b=8'h55 -> y=FF; op=011 a=b -> y=00, zero=1.
REQ-036 out_ready=0, stream 3 inputs -> first two accepted, in_ready=0 in state TWO, third held; raise out_ready -> outputs in order, y stable while stalled.
REQ-037 CNT_W=4, accept 17 inputs -> op_count=1 (wrap); assert clr_count with accept -> op_count=0.
REQ-038 State TWO, pull rst_n low one cycle -> out_valid=0, y=0, op_count=0, in_ready=1 afterwards, and no stale result delivered.
REQ-039 Random in_valid/out_ready for 10k cycles, WIDTH=13 -> scoreboard matches every result in order, and the count of accepted inputs equals op_count.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared encodings for the logic unit: op select values and the
// occupancy states of the two-entry result pipe.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Number of results currently held: none, main only, main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/logic_op.sv
// Combinational bitwise operator: evaluates one of eight logic functions
// of a and b. No carries, so every bit is independent.
module logic_op
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = a;
        case (op_e'(op))
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered logic unit with a two-entry (main + skid) output buffer so
// in_ready depends only on registered state, plus an accepted-op counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  y,
    output logic              zero,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  op_count,
    output pipe_state_e       state_dbg
);

    // Handshake: a beat moves when valid && ready are both high at a rising
    // edge; in_ready comes only from state, never from out_ready.
    pipe_state_e      state_q, state_nxt;
    logic [WIDTH-1:0] main_q, skid_q, op_res;
    logic [CNT_W-1:0] op_count_q;
    logic             accept, xfer;
    logic             load_main, load_skid, move_skid;

    logic_op #(.WIDTH(WIDTH)) u_logic_op (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (op_res)
    );

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign y         = main_q;
    assign zero      = (main_q == '0);
    assign op_count  = op_count_q;
    assign state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_EMPTY;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && !xfer) begin
                    state_nxt = ST_TWO;
                    load_skid = 1'b1;
                end else if (accept && xfer) begin
                    load_main = 1'b1;
                end else if (xfer) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // Older result sits in main; skid is promoted once it leaves.
                if (xfer) begin
                    state_nxt = ST_ONE;
                    move_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)      main_q <= op_res;
            else if (move_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= op_res;
        end
    end

    // Clear has priority over a coincident accept.
    always_ff @(posedge clk) begin
        if (!rst_n)         op_count_q <= '0;
        else if (clr_count) op_count_q <= '0;
        else if (accept)    op_count_q <= op_count_q + 1'b1;
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed checks on an 8-bit / 4-bit-counter
// instance, random traffic on a 13-bit instance, both scoreboarded.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int AW = 8;
    localparam int AC = 4;
    localparam int BW = 13;
    localparam int BC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    // instance A signals
    logic          a_in_valid = 1'b0, a_out_ready = 1'b0, a_clr = 1'b0;
    logic [2:0]    a_op = '0;
    logic [AW-1:0] a_a = '0, a_b = '0;
    logic          a_in_ready, a_out_valid, a_zero;
    logic [AW-1:0] a_y;
    logic [AC-1:0] a_op_count;
    pipe_state_e   a_state;

    // instance B signals
    logic          b_in_valid = 1'b0, b_out_ready = 1'b0, b_clr = 1'b0;
    logic [2:0]    b_op = '0;
    logic [BW-1:0] b_a = '0, b_b = '0;
    logic          b_in_ready, b_out_valid, b_zero;
    logic [BW-1:0] b_y;
    logic [BC-1:0] b_op_count;
    pipe_state_e   b_state;

    // scoreboards and models
    logic [AW-1:0] exp_q_a[$];
    logic [BW-1:0] exp_q_b[$];
    logic [AC-1:0] cnt_a = '0;
    logic [BC-1:0] cnt_b = '0;
    int            b_total = 0;

    logic_unit_pipe #(.WIDTH(AW), .CNT_W(AC)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .op(a_op), .a(a_a), .b(a_b), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .y(a_y), .zero(a_zero), .clr_count(a_clr), .op_count(a_op_count),
        .state_dbg(a_state)
    );

    logic_unit_pipe #(.WIDTH(BW), .CNT_W(BC)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .a(b_a), .b(b_b), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .y(b_y), .zero(b_zero), .clr_count(b_clr), .op_count(b_op_count),
        .state_dbg(b_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: the eight bitwise functions on wide operands.
    function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x,
                                           input logic [63:0] z);
        case (o)
            3'd0:    return ~x;
            3'd1:    return x & z;
            3'd2:    return x | z;
            3'd3:    return x ^ z;
            3'd4:    return ~(x & z);
            3'd5:    return ~(x | z);
            3'd6:    return ~(x ^ z);
            default: return x;
        endcase
    endfunction

    // Expected-value producers: record every accepted input at the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q_a.delete();
            cnt_a = '0;
        end else begin
            if (a_in_valid && a_in_ready)
                exp_q_a.push_back(AW'(ref_op(a_op, 64'(a_a), 64'(a_b))));
            if (a_clr)                          cnt_a = '0;
            else if (a_in_valid && a_in_ready)  cnt_a = cnt_a + 1'b1;
        end
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q_b.delete();
            cnt_b = '0;
        end else begin
            if (b_in_valid && b_in_ready) begin
                exp_q_b.push_back(BW'(ref_op(b_op, 64'(b_a), 64'(b_b))));
                b_total++;
            end
            if (b_clr)                          cnt_b = '0;
            else if (b_in_valid && b_in_ready)  cnt_b = cnt_b + 1'b1;
        end
    end

    // Monitors: occupancy, head-of-queue result and counter every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            check("a_out_valid", a_out_valid, exp_q_a.size() > 0);
            check("a_in_ready", a_in_ready, exp_q_a.size() < 2);
            check("a_op_count", a_op_count, cnt_a);
            if (exp_q_a.size() > 0) begin
                check("a_y", a_y, exp_q_a[0]);
                check("a_zero", a_zero, exp_q_a[0] == '0);
                if (a_out_ready) void'(exp_q_a.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("b_out_valid", b_out_valid, exp_q_b.size() > 0);
            check("b_in_ready", b_in_ready, exp_q_b.size() < 2);
            check("b_op_count", b_op_count, cnt_b);
            if (exp_q_b.size() > 0) begin
                check("b_y", b_y, exp_q_b[0]);
                check("b_zero", b_zero, exp_q_b[0] == '0);
                if (b_out_ready) void'(exp_q_b.pop_front());
            end
        end
    end

    // Driver: offer one input on A and hold it until accepted (bounded).
    task automatic a_send(input logic [2:0] o, input logic [AW-1:0] x,
                          input logic [AW-1:0] z);
        logic rdy;
        logic done;
        done = 1'b0;
        a_op = o;
        a_a = x;
        a_b = z;
        a_in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = a_in_ready;
            @(posedge clk);
            if (rdy) done = 1'b1;
        end
        #1;
        a_in_valid = 1'b0;
        check("a_send_accept", done, 1'b1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] sweep_exp[8];

    initial begin
        sweep_exp = '{8'h33, 8'h88, 8'hEE, 8'h66, 8'h77, 8'h11, 8'h99, 8'hCC};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_y", a_y, 8'h00);
        check("rst_zero", a_zero, 1'b1);
        check("rst_op_count", a_op_count, 4'd0);

        // first transaction, latency 1
        a_out_ready = 1'b1;
        a_send(3'd0, 8'h0F, 8'h00);
        check("lat_y", a_y, 8'hF0);
        check("lat_zero", a_zero, 1'b0);
        check("lat_out_valid", a_out_valid, 1'b1);
        check("lat_op_count", a_op_count, 4'd1);

        // op sweep
        for (int i = 0; i < 8; i++) begin
            a_send(3'(i), 8'hCC, 8'hAA);
            check("sweep_y", a_y, sweep_exp[i]);
        end
        a_send(3'd6, 8'h55, 8'h55);
        check("xnor_eq_y", a_y, 8'hFF);
        a_send(3'd3, 8'h5A, 8'h5A);
        check("xor_eq_y", a_y, 8'h00);
        check("xor_eq_zero", a_zero, 1'b1);
        step();

        // backpressure: two fill the pipe, third waits
        a_out_ready = 1'b0;
        a_send(3'd1, 8'hF0, 8'h3C);
        a_send(3'd2, 8'hF0, 8'h0F);
        check("full_in_ready", a_in_ready, 1'b0);
        a_op = 3'd3;
        a_a = 8'hFF;
        a_b = 8'h0F;
        a_in_valid = 1'b1;
        repeat (3) begin
            step();
            check("stall_in_ready", a_in_ready, 1'b0);
            check("stall_y", a_y, 8'h30);
        end
        a_out_ready = 1'b1;
        a_send(3'd3, 8'hFF, 8'h0F);
        check("third_y", a_y, 8'hF0);
        step();

        // counter clear, wrap, and clear-beats-accept
        a_clr = 1'b1;
        step();
        a_clr = 1'b0;
        check("clr_count", a_op_count, 4'd0);
        for (int i = 0; i < 17; i++)
            a_send(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)));
        check("wrap_count", a_op_count, 4'd1);
        a_clr = 1'b1;
        a_send(3'd7, 8'h3C, 8'h00);
        a_clr = 1'b0;
        check("clr_win_count", a_op_count, 4'd0);
        check("clr_win_y", a_y, 8'h3C);
        step();

        // reset while full
        a_out_ready = 1'b0;
        a_send(3'd0, 8'h11, 8'h00);
        a_send(3'd1, 8'hFF, 8'hAA);
        check("pre_rst_in_ready", a_in_ready, 1'b0);
        a_out_ready = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_out_valid", a_out_valid, 1'b0);
        check("mid_rst_y", a_y, 8'h00);
        check("mid_rst_zero", a_zero, 1'b1);
        check("mid_rst_op_count", a_op_count, 4'd0);
        check("mid_rst_in_ready", a_in_ready, 1'b1);
        step();
        check("post_rst_out_valid", a_out_valid, 1'b0);

        // random traffic on the wide instance
        for (int i = 0; i < 10000; i++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_op        = 3'($urandom_range(0, 7));
            b_a         = BW'($urandom_range(0, (1 << BW) - 1));
            b_b         = ($urandom_range(0, 7) == 0) ? b_a
                                                      : BW'($urandom_range(0, (1 << BW) - 1));
            step();
        end
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        repeat (4) step();
        check("b_drained", exp_q_b.size(), 0);
        check("a_drained", exp_q_a.size(), 0);
        check("b_total_count", b_op_count, BC'(b_total));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
